dcache_ctrl: RTL and testbench

Two-way set-associative data-cache controller that drives the tag0/tag1 and data block0/block1 RAMs. It serves word loads and stores from the CPU pipeline and selects the victim way by the per-way used bit. Dirty victims are written back, and blocks are refilled from main memory over a valid/ready block interface. It sits between the pipeline MEM stage and the main-memory port.

---
 rtl/dcache_ctrl.sv | 283 ++++++++++++++++++++++++++++
 tb/tb_dcache_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_ctrl.sv
// Two-way set-associative write-back data-cache controller between the MEM stage and main memory.
// Latency: hit responds 2 cycles after accept; clean miss adds RF_REQ/RF_WAIT/FILL plus memory waits.
// Backpressure: cpu_req_ready only in IDLE; mem_req_* held stable until mem_req_ready.
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   cpu_req_* / cpu_resp_*      word load/store request and one-cycle response pulse
//   ram_index                   shared set index to tag0/tag1/data0/data1 RAMs
//   tagN_* / dataN_*            RAM read data (1-cycle registered address), write data and enables
//   mem_req_* / mem_resp_*      block writeback/refill port (valid/ready request, pulsed response)
//   hit_cnt, miss_cnt, wb_cnt   performance counters, present only with DCACHE_PERF_CNT_EN
//
// Optional feature macro: DCACHE_PERF_CNT_EN (adds the performance counter outputs).
module dcache_ctrl #(
    parameter int INDEX_BIT          = 10,
    parameter int BLOCK_SIZE_WORDS   = 4,
    parameter int NUMBER_OF_SETS     = 1024,
    parameter int TOTAL_TAG_SIZE_BIT = 23
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            cpu_req_valid,
    output logic                            cpu_req_ready,
    input  logic                            cpu_req_we,
    input  logic [31:0]                     cpu_req_addr,
    input  logic [31:0]                     cpu_req_wdata,
    output logic                            cpu_resp_valid,
    output logic [31:0]                     cpu_resp_rdata,
    output logic [INDEX_BIT-1:0]            ram_index,
    input  logic [TOTAL_TAG_SIZE_BIT-1:0]   tag0_rdata,
    input  logic [TOTAL_TAG_SIZE_BIT-1:0]   tag1_rdata,
    output logic [TOTAL_TAG_SIZE_BIT-1:0]   tag0_wdata,
    output logic [TOTAL_TAG_SIZE_BIT-1:0]   tag1_wdata,
    output logic                            tag0_we,
    output logic                            tag1_we,
    input  logic [BLOCK_SIZE_WORDS*32-1:0]  data0_rdata,
    input  logic [BLOCK_SIZE_WORDS*32-1:0]  data1_rdata,
    output logic [BLOCK_SIZE_WORDS*32-1:0]  data0_wdata,
    output logic [BLOCK_SIZE_WORDS*32-1:0]  data1_wdata,
    output logic                            data0_we,
    output logic                            data1_we,
    output logic                            mem_req_valid,
    input  logic                            mem_req_ready,
    output logic                            mem_req_we,
    output logic [31:0]                     mem_req_addr,
    output logic [BLOCK_SIZE_WORDS*32-1:0]  mem_req_wdata,
    input  logic                            mem_resp_valid,
    input  logic [BLOCK_SIZE_WORDS*32-1:0]  mem_resp_rdata
`ifdef DCACHE_PERF_CNT_EN
    ,
    output logic [31:0]                     hit_cnt,
    output logic [31:0]                     miss_cnt,
    output logic [31:0]                     wb_cnt
`endif
);

    localparam int BLK_W = BLOCK_SIZE_WORDS * 32;
    localparam int OFF_W = $clog2(BLOCK_SIZE_WORDS);
    localparam int IDX_W = $clog2(NUMBER_OF_SETS);
    localparam int TAG_W = 32 - INDEX_BIT - OFF_W;
    localparam int TT    = TOTAL_TAG_SIZE_BIT;
    localparam int V_B   = TT - 1;   // valid
    localparam int U_B   = TT - 2;   // used (most recently touched)
    localparam int D_B   = TT - 3;   // dirty

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_WB_REQ, S_RF_REQ, S_RF_WAIT, S_FILL
    } state_t;

    state_t            state_q, state_d;
    logic              req_we_q, req_we_d;
    logic [31:0]       req_addr_q, req_addr_d;
    logic [31:0]       req_wdata_q, req_wdata_d;
    logic              victim_q, victim_d;
    logic [TAG_W-1:0]  vic_tag_q, vic_tag_d;
    logic [BLK_W-1:0]  vic_blk_q, vic_blk_d;
    logic [TT-1:0]     oth_tag_q, oth_tag_d;   // tag entry of the non-victim way
    logic [BLK_W-1:0]  fill_blk_q, fill_blk_d;
    logic              resp_vld_q, resp_vld_d;
    logic [31:0]       resp_dat_q, resp_dat_d;

    logic [TT-1:0]     tag_rd  [2];
    logic [BLK_W-1:0]  data_rd [2];
    logic [TT-1:0]     tag_wd  [2];
    logic [BLK_W-1:0]  data_wd [2];
    logic              tag_wen [2];
    logic              data_wen[2];

    logic [TAG_W-1:0]  req_tag;
    logic [IDX_W-1:0]  req_idx;
    logic [OFF_W-1:0]  req_off;
    logic              hit0, hit1, hit_any, hit_way, vic_way;
    logic              mreq_vld;

    function automatic logic [BLK_W-1:0] put_word(input logic [BLK_W-1:0] blk,
                                                  input logic [OFF_W-1:0] off,
                                                  input logic [31:0]      w);
        logic [BLK_W-1:0] r;
        r = blk;
        r[{off, 5'd0} +: 32] = w;
        return r;
    endfunction

    function automatic logic [31:0] get_word(input logic [BLK_W-1:0] blk,
                                             input logic [OFF_W-1:0] off);
        return blk[{off, 5'd0} +: 32];
    endfunction

    assign tag_rd[0]  = tag0_rdata;
    assign tag_rd[1]  = tag1_rdata;
    assign data_rd[0] = data0_rdata;
    assign data_rd[1] = data1_rdata;

    assign req_tag = req_addr_q[31 -: TAG_W];
    assign req_idx = req_addr_q[OFF_W +: IDX_W];
    assign req_off = req_addr_q[OFF_W-1:0];

    assign hit0    = tag0_rdata[V_B] && (tag0_rdata[TAG_W-1:0] == req_tag);
    assign hit1    = tag1_rdata[V_B] && (tag1_rdata[TAG_W-1:0] == req_tag);
    assign hit_any = hit0 | hit1;
    assign hit_way = ~hit0;

    // Victim: an invalid way first (way0 preferred), else the way not recently used;
    // equal used bits fall back to way0.
    assign vic_way = tag0_rdata[V_B] &
                     (~tag1_rdata[V_B] | (tag0_rdata[U_B] & ~tag1_rdata[U_B]));

    always_comb begin
        state_d     = state_q;
        req_we_d    = req_we_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        victim_d    = victim_q;
        vic_tag_d   = vic_tag_q;
        vic_blk_d   = vic_blk_q;
        oth_tag_d   = oth_tag_q;
        fill_blk_d  = fill_blk_q;
        resp_vld_d  = 1'b0;
        resp_dat_d  = resp_dat_q;
        for (int i = 0; i < 2; i++) begin
            tag_wd[i]   = '0;
            data_wd[i]  = '0;
            tag_wen[i]  = 1'b0;
            data_wen[i] = 1'b0;
        end
        mreq_vld      = 1'b0;
        mem_req_we    = 1'b0;
        mem_req_addr  = '0;
        mem_req_wdata = '0;
        cpu_req_ready = (state_q == S_IDLE);
        ram_index     = (state_q == S_IDLE) ? cpu_req_addr[OFF_W +: IDX_W] : req_idx;

        case (state_q)
            S_IDLE: begin
                if (cpu_req_valid) begin
                    req_we_d    = cpu_req_we;
                    req_addr_d  = cpu_req_addr;
                    req_wdata_d = cpu_req_wdata;
                    state_d     = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                if (hit_any) begin
                    tag_wen[hit_way] = 1'b1;
                    tag_wd[hit_way]  = {1'b1, 1'b1, tag_rd[hit_way][D_B] | req_we_q, req_tag};
                    if (tag_rd[~hit_way][V_B]) begin
                        tag_wen[~hit_way] = 1'b1;
                        tag_wd[~hit_way]  = {1'b1, 1'b0, tag_rd[~hit_way][D_B],
                                             tag_rd[~hit_way][TAG_W-1:0]};
                    end
                    if (req_we_q) begin
                        data_wen[hit_way] = 1'b1;
                        data_wd[hit_way]  = put_word(data_rd[hit_way], req_off, req_wdata_q);
                    end
                    resp_vld_d = 1'b1;
                    resp_dat_d = req_we_q ? 32'd0 : get_word(data_rd[hit_way], req_off);
                    state_d    = S_IDLE;
                end else begin
                    // Snapshot victim and sibling state so later states do not depend
                    // on the RAM read port staying undisturbed.
                    victim_d  = vic_way;
                    vic_tag_d = tag_rd[vic_way][TAG_W-1:0];
                    vic_blk_d = data_rd[vic_way];
                    oth_tag_d = tag_rd[~vic_way];
                    state_d   = (tag_rd[vic_way][V_B] && tag_rd[vic_way][D_B]) ? S_WB_REQ
                                                                               : S_RF_REQ;
                end
            end
            S_WB_REQ: begin
                mreq_vld      = 1'b1;
                mem_req_we    = 1'b1;
                mem_req_addr  = {vic_tag_q, req_idx, {OFF_W{1'b0}}};
                mem_req_wdata = vic_blk_q;
                if (mem_req_ready) state_d = S_RF_REQ;
            end
            S_RF_REQ: begin
                mreq_vld     = 1'b1;
                mem_req_addr = {req_tag, req_idx, {OFF_W{1'b0}}};
                if (mem_req_ready) state_d = S_RF_WAIT;
            end
            S_RF_WAIT: begin
                if (mem_resp_valid) begin
                    fill_blk_d = mem_resp_rdata;
                    state_d    = S_FILL;
                end
            end
            S_FILL: begin
                tag_wen[victim_q]  = 1'b1;
                tag_wd[victim_q]   = {1'b1, 1'b1, req_we_q, req_tag};
                data_wen[victim_q] = 1'b1;
                data_wd[victim_q]  = req_we_q ? put_word(fill_blk_q, req_off, req_wdata_q)
                                              : fill_blk_q;
                if (oth_tag_q[V_B]) begin
                    tag_wen[~victim_q] = 1'b1;
                    tag_wd[~victim_q]  = {1'b1, 1'b0, oth_tag_q[D_B], oth_tag_q[TAG_W-1:0]};
                end
                resp_vld_d = 1'b1;
                resp_dat_d = req_we_q ? 32'd0 : get_word(fill_blk_q, req_off);
                state_d    = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Enables are qualified by rst_n so a reset cycle never commits a RAM write.
    assign tag0_we       = tag_wen[0]  & rst_n;
    assign tag1_we       = tag_wen[1]  & rst_n;
    assign data0_we      = data_wen[0] & rst_n;
    assign data1_we      = data_wen[1] & rst_n;
    assign tag0_wdata    = tag_wd[0];
    assign tag1_wdata    = tag_wd[1];
    assign data0_wdata   = data_wd[0];
    assign data1_wdata   = data_wd[1];
    assign mem_req_valid = mreq_vld & rst_n;

    assign cpu_resp_valid = resp_vld_q;
    assign cpu_resp_rdata = resp_dat_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            resp_vld_q <= 1'b0;
            resp_dat_q <= '0;
        end else begin
            state_q    <= state_d;
            resp_vld_q <= resp_vld_d;
            resp_dat_q <= resp_dat_d;
        end
    end

    // Datapath holding registers are only consumed after being loaded, so no reset.
    always_ff @(posedge clk) begin
        req_we_q    <= req_we_d;
        req_addr_q  <= req_addr_d;
        req_wdata_q <= req_wdata_d;
        victim_q    <= victim_d;
        vic_tag_q   <= vic_tag_d;
        vic_blk_q   <= vic_blk_d;
        oth_tag_q   <= oth_tag_d;
        fill_blk_q  <= fill_blk_d;
    end

`ifdef DCACHE_PERF_CNT_EN
    logic [31:0] hit_cnt_q, miss_cnt_q, wb_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            wb_cnt_q   <= '0;
        end else begin
            if (state_q == S_LOOKUP && hit_any)       hit_cnt_q  <= hit_cnt_q + 32'd1;
            if (state_q == S_LOOKUP && !hit_any)      miss_cnt_q <= miss_cnt_q + 32'd1;
            if (state_q == S_WB_REQ && mem_req_ready) wb_cnt_q   <= wb_cnt_q + 32'd1;
        end
    end

    assign hit_cnt  = hit_cnt_q;
    assign miss_cnt = miss_cnt_q;
    assign wb_cnt   = wb_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
module tb_dcache_ctrl;

    logic         clk;
    logic         rst_n;
    logic         cpu_req_valid, cpu_req_ready, cpu_req_we;
    logic [31:0]  cpu_req_addr, cpu_req_wdata;
    logic         cpu_resp_valid;
    logic [31:0]  cpu_resp_rdata;
    logic [9:0]   ram_index;
    logic [22:0]  tag0_rdata, tag1_rdata, tag0_wdata, tag1_wdata;
    logic         tag0_we, tag1_we;
    logic [127:0] data0_rdata, data1_rdata, data0_wdata, data1_wdata;
    logic         data0_we, data1_we;
    logic         mem_req_valid, mem_req_ready, mem_req_we;
    logic [31:0]  mem_req_addr;
    logic [127:0] mem_req_wdata;
    logic         mem_resp_valid;
    logic [127:0] mem_resp_rdata;
`ifdef DCACHE_PERF_CNT_EN
    logic [31:0]  hit_cnt, miss_cnt, wb_cnt;
`endif

    dcache_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cpu_req_valid  (cpu_req_valid),
        .cpu_req_ready  (cpu_req_ready),
        .cpu_req_we     (cpu_req_we),
        .cpu_req_addr   (cpu_req_addr),
        .cpu_req_wdata  (cpu_req_wdata),
        .cpu_resp_valid (cpu_resp_valid),
        .cpu_resp_rdata (cpu_resp_rdata),
        .ram_index      (ram_index),
        .tag0_rdata     (tag0_rdata),
        .tag1_rdata     (tag1_rdata),
        .tag0_wdata     (tag0_wdata),
        .tag1_wdata     (tag1_wdata),
        .tag0_we        (tag0_we),
        .tag1_we        (tag1_we),
        .data0_rdata    (data0_rdata),
        .data1_rdata    (data1_rdata),
        .data0_wdata    (data0_wdata),
        .data1_wdata    (data1_wdata),
        .data0_we       (data0_we),
        .data1_we       (data1_we),
        .mem_req_valid  (mem_req_valid),
        .mem_req_ready  (mem_req_ready),
        .mem_req_we     (mem_req_we),
        .mem_req_addr   (mem_req_addr),
        .mem_req_wdata  (mem_req_wdata),
        .mem_resp_valid (mem_resp_valid),
        .mem_resp_rdata (mem_resp_rdata)
`ifdef DCACHE_PERF_CNT_EN
        ,
        .hit_cnt        (hit_cnt),
        .miss_cnt       (miss_cnt),
        .wb_cnt         (wb_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM models: registered read address, write on the rising edge.
    logic [22:0]  tag0_mem  [1024];
    logic [22:0]  tag1_mem  [1024];
    logic [127:0] data0_mem [1024];
    logic [127:0] data1_mem [1024];
    logic [9:0]   ram_addr_q;
    logic         ram_clr;

    always @(posedge clk) begin
        ram_addr_q <= ram_index;
        if (ram_clr) begin
            for (int i = 0; i < 1024; i++) begin
                tag0_mem[i]  <= '0;
                tag1_mem[i]  <= '0;
                data0_mem[i] <= '0;
                data1_mem[i] <= '0;
            end
        end else begin
            if (tag0_we)  tag0_mem[ram_index]  <= tag0_wdata;
            if (tag1_we)  tag1_mem[ram_index]  <= tag1_wdata;
            if (data0_we) data0_mem[ram_index] <= data0_wdata;
            if (data1_we) data1_mem[ram_index] <= data1_wdata;
        end
    end

    assign tag0_rdata  = tag0_mem[ram_addr_q];
    assign tag1_rdata  = tag1_mem[ram_addr_q];
    assign data0_rdata = data0_mem[ram_addr_q];
    assign data1_rdata = data1_mem[ram_addr_q];

    int wr_cnt   = 0;
    int resp_cnt = 0;
    always @(posedge clk) begin
        if (tag0_we | tag1_we | data0_we | data1_we) wr_cnt <= wr_cnt + 1;
        if (cpu_resp_valid) resp_cnt <= resp_cnt + 1;
    end

    int tests = 0;
    int fails = 0;

`define CHK(nm, obs, exp) \
    begin \
        tests++; \
        assert ((obs) === (exp)) else begin \
            fails++; \
            $error("FAIL %s: observed %0h expected %0h", nm, (obs), (exp)); \
        end \
    end

    task automatic cpu_issue(input logic we, input logic [31:0] a, input logic [31:0] d);
        cpu_req_valid = 1'b1;
        cpu_req_we    = we;
        cpu_req_addr  = a;
        cpu_req_wdata = d;
        @(negedge clk);
        cpu_req_valid = 1'b0;
        cpu_req_we    = 1'b0;
        cpu_req_addr  = '0;
        cpu_req_wdata = '0;
    endtask

    task automatic wait_mem_vld(input string nm);
        int n = 0;
        while (!mem_req_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (n >= 50) begin
            fails++;
            $error("FAIL %s: wait for mem_req_valid expired after %0d cycles", nm, n);
        end
        `CHK({nm, "_mem_req_valid"}, mem_req_valid, 1'b1)
    endtask

    task automatic mem_serve_req(input string nm, input logic exp_we,
                                 input logic [31:0] exp_addr);
        wait_mem_vld(nm);
        `CHK({nm, "_we"}, mem_req_we, exp_we)
        `CHK({nm, "_addr"}, mem_req_addr, exp_addr)
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
    endtask

    task automatic mem_give(input logic [127:0] d);
        mem_resp_valid = 1'b1;
        mem_resp_rdata = d;
        @(negedge clk);
        mem_resp_valid = 1'b0;
        mem_resp_rdata = '0;
    endtask

    task automatic wait_resp(input string nm, input logic [31:0] exp);
        int n = 0;
        while (!cpu_resp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (n >= 50) begin
            fails++;
            $error("FAIL %s: wait for cpu_resp_valid expired after %0d cycles", nm, n);
        end
        `CHK({nm, "_resp_valid"}, cpu_resp_valid, 1'b1)
        `CHK({nm, "_rdata"}, cpu_resp_rdata, exp)
        @(negedge clk);
        `CHK({nm, "_resp_pulse"}, cpu_resp_valid, 1'b0)
        `CHK({nm, "_rdata_hold"}, cpu_resp_rdata, exp)
    endtask

    localparam logic [127:0] BLK_A   = {32'd4, 32'd3, 32'd2, 32'd1};
    localparam logic [127:0] BLK_A_S = {32'd4, 32'hDEADBEEF, 32'd2, 32'd1};
    localparam logic [127:0] BLK_B   = {32'd8, 32'd7, 32'd6, 32'd5};
    localparam logic [127:0] BLK_C   = {32'hC, 32'hB, 32'hA, 32'h9};

    initial begin
        int wr0, rs0;
        rst_n          = 1'b0;
        ram_clr        = 1'b1;
        cpu_req_valid  = 1'b0;
        cpu_req_we     = 1'b0;
        cpu_req_addr   = '0;
        cpu_req_wdata  = '0;
        mem_req_ready  = 1'b0;
        mem_resp_valid = 1'b0;
        mem_resp_rdata = '0;
        repeat (3) @(negedge clk);
        ram_clr = 1'b0;

        // Reset state
        `CHK("rst_cpu_req_ready", cpu_req_ready, 1'b1)
        `CHK("rst_resp_valid", cpu_resp_valid, 1'b0)
        `CHK("rst_resp_rdata", cpu_resp_rdata, 32'd0)
        `CHK("rst_mem_req_valid", mem_req_valid, 1'b0)
        `CHK("rst_mem_req_we", mem_req_we, 1'b0)
        `CHK("rst_mem_req_addr", mem_req_addr, 32'd0)
        `CHK("rst_mem_req_wdata", mem_req_wdata, 128'd0)
        `CHK("rst_ram_we", {tag0_we, tag1_we, data0_we, data1_we}, 4'b0000)
        tests++;
        if (cpu_req_ready !== 1'b1 || cpu_resp_valid !== 1'b0 || mem_req_valid !== 1'b0 ||
            {tag0_we, tag1_we, data0_we, data1_we} !== 4'b0000) begin
            fails++;
            $error("FAIL rst_state: ready=%b resp=%b mreq=%b we=%b", cpu_req_ready,
                   cpu_resp_valid, mem_req_valid, {tag0_we, tag1_we, data0_we, data1_we});
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Cold load 0x1235: refill way0
        cpu_issue(1'b0, 32'h0000_1235, 32'd0);
        mem_serve_req("rf1", 1'b0, 32'h0000_1234);
        `CHK("rf1_wait_req_drop", mem_req_valid, 1'b0)
        mem_give(BLK_A);
        wait_resp("ld1", 32'd2);
        `CHK("ld1_tag0", tag0_mem[10'h08D], 23'h600001)
        `CHK("ld1_data0", data0_mem[10'h08D], BLK_A)
        `CHK("ld1_tag1", tag1_mem[10'h08D], 23'h000000)

        // Stray memory response while idle must be ignored
        wr0 = wr_cnt;
        rs0 = resp_cnt;
        mem_give(128'hFFFF);
        repeat (3) @(negedge clk);
        `CHK("stray_resp_writes", wr_cnt - wr0, 0)
        `CHK("stray_resp_cpu", resp_cnt - rs0, 0)

        // Reload hit: response exactly 2 cycles after acceptance
        cpu_issue(1'b0, 32'h0000_1235, 32'd0);
        `CHK("hit_c1_resp", cpu_resp_valid, 1'b0)
        `CHK("hit_c1_mem", mem_req_valid, 1'b0)
        @(negedge clk);
        `CHK("hit_c2_resp", cpu_resp_valid, 1'b1)
        `CHK("hit_c2_rdata", cpu_resp_rdata, 32'd2)
        `CHK("hit_c2_mem", mem_req_valid, 1'b0)
        `CHK("hit_c2_ready", cpu_req_ready, 1'b1)
        @(negedge clk);
        `CHK("hit_pulse", cpu_resp_valid, 1'b0)

        // Store hit to word2 of way0
        cpu_issue(1'b1, 32'h0000_1236, 32'hDEADBEEF);
        wait_resp("st", 32'd0);
        `CHK("st_tag0", tag0_mem[10'h08D], 23'h700001)
        `CHK("st_data0", data0_mem[10'h08D], BLK_A_S)

        // Load 0x2234: way1 is invalid, refill into it
        cpu_issue(1'b0, 32'h0000_2234, 32'd0);
        mem_serve_req("rf2", 1'b0, 32'h0000_2234);
        mem_give(BLK_B);
        wait_resp("ld2", 32'd5);
        `CHK("ld2_tag1", tag1_mem[10'h08D], 23'h600002)
        `CHK("ld2_tag0_used0", tag0_mem[10'h08D], 23'h500001)

        // Load 0x3234: victim way0 is dirty, write back under backpressure
        cpu_issue(1'b0, 32'h0000_3234, 32'd0);
        wait_mem_vld("wb_hold");
        for (int i = 0; i < 5; i++) begin
            `CHK("wb_hold_valid", mem_req_valid, 1'b1)
            `CHK("wb_hold_we", mem_req_we, 1'b1)
            `CHK("wb_hold_addr", mem_req_addr, 32'h0000_1234)
            `CHK("wb_hold_wdata", mem_req_wdata, BLK_A_S)
            `CHK("wb_hold_cpu_ready", cpu_req_ready, 1'b0)
            @(negedge clk);
        end
        mem_serve_req("wb", 1'b1, 32'h0000_1234);
        mem_serve_req("rf3", 1'b0, 32'h0000_3234);
        mem_give(BLK_C);
        wait_resp("ld3", 32'h9);
        `CHK("ld3_tag0", tag0_mem[10'h08D], 23'h600003)
        `CHK("ld3_tag1_used0", tag1_mem[10'h08D], 23'h400002)
        `CHK("ld3_data0", data0_mem[10'h08D], BLK_C)
`ifdef DCACHE_PERF_CNT_EN
        `CHK("perf_hit", hit_cnt, 32'd2)
        `CHK("perf_miss", miss_cnt, 32'd3)
        `CHK("perf_wb", wb_cnt, 32'd1)
`endif

        // Reset while waiting for refill data
        cpu_issue(1'b0, 32'h0000_4235, 32'd0);
        mem_serve_req("rf4", 1'b0, 32'h0000_4234);
        wr0 = wr_cnt;
        rs0 = resp_cnt;
        rst_n = 1'b0;
        @(negedge clk);
        `CHK("midrst_mem_req_valid", mem_req_valid, 1'b0)
        `CHK("midrst_cpu_ready", cpu_req_ready, 1'b1)
        mem_give(128'h1111_2222_3333_4444);
        rst_n = 1'b1;
        mem_give(128'h5555_6666_7777_8888);
        repeat (3) @(negedge clk);
        `CHK("midrst_writes", wr_cnt - wr0, 0)
        `CHK("midrst_cpu_resp", resp_cnt - rs0, 0)
        `CHK("midrst_tag0", tag0_mem[10'h08D], 23'h600003)
        `CHK("midrst_tag1", tag1_mem[10'h08D], 23'h400002)
        `CHK("midrst_mem_idle", mem_req_valid, 1'b0)
`ifdef DCACHE_PERF_CNT_EN
        `CHK("midrst_perf_hit_clr", hit_cnt, 32'd0)
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
